// File: rtl/mb_valtrain_pkg.sv
// Shared constants and encodings for the mainband VALTRAIN pattern checker.
package mb_valtrain_pkg;

   localparam logic [7:0] VALTRAIN_BYTE = 8'b00001111;

   typedef enum logic {
      MODE_ITER   = 1'b0,
      MODE_CONSEC = 1'b1
   } mode_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/mb_valtrain_seg_cmp.sv
// Combinational per-beat comparison of a valid-lane beat against the replicated
// VALTRAIN byte: total bit mismatches, per-segment match and trailing-match run.
module mb_valtrain_seg_cmp
   import mb_valtrain_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int K      = DATA_W / 8,
   parameter int MISM_W = $clog2(DATA_W + 1),
   parameter int TRL_W  = $clog2(K + 1)
) (
   input  logic [DATA_W-1:0] i_data,
   output logic [MISM_W-1:0] o_mism,
   output logic [K-1:0]      o_seg_match,
   output logic [TRL_W-1:0]  o_trail_run
);

   logic [DATA_W-1:0] diff;
   logic              still;

   assign diff = i_data ^ {K{VALTRAIN_BYTE}};

   always_comb begin
      o_mism = '0;
      for (int unsigned b = 0; b < DATA_W; b++) begin
         o_mism = o_mism + MISM_W'(diff[b]);
      end
   end

   always_comb begin
      o_seg_match = '0;
      for (int unsigned j = 0; j < K; j++) begin
         o_seg_match[j] = (i_data[8*j +: 8] == VALTRAIN_BYTE);
      end
   end

   // Segment K-1 is latest in time, so the run that survives into the next beat
   // is the unbroken match streak counted downward from the top segment.
   always_comb begin
      o_trail_run = '0;
      still       = 1'b1;
      for (int unsigned j = 0; j < K; j++) begin
         if (still && o_seg_match[K-1-j]) begin
            o_trail_run = o_trail_run + 1'b1;
         end else begin
            still = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mb_valtrain_checker.sv
// VALTRAIN pattern checker: ITER mode accumulates bit errors over a fixed budget,
// CONSEC mode searches for a streak of clean iterations within the same budget.
module mb_valtrain_checker
   import mb_valtrain_pkg::*;
#(
   parameter int DATA_W        = 32,
   parameter int ITER_COUNT    = 128,
   parameter int CONSEC_TARGET = 16,
   parameter int ERR_W         = 12,
   parameter int RUN_W         = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic              i_mode,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_data_valid,
   input  logic [ERR_W-1:0]  i_error_threshold,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ERR_W-1:0]  o_error_count,
   output logic [RUN_W-1:0]  o_consec_count
);

   localparam int K      = DATA_W / 8;
   localparam int MISM_W = $clog2(DATA_W + 1);
   localparam int TRL_W  = $clog2(K + 1);
   localparam int IT_W   = $clog2(ITER_COUNT + 1);
   localparam int SUM_W  = ((ERR_W > MISM_W) ? ERR_W : MISM_W) + 1;
   localparam int RUN_SW = RUN_W + 1;

   localparam logic [IT_W-1:0]   ITER_LAST  = IT_W'(ITER_COUNT);
   localparam logic [IT_W-1:0]   ITER_STEP  = IT_W'(K);
   localparam logic [RUN_W-1:0]  RUN_TARGET = RUN_W'(CONSEC_TARGET);
   localparam logic [RUN_SW-1:0] RUN_STEP   = RUN_SW'(K);
   localparam logic [RUN_SW-1:0] RUN_MAX    = {1'b0, {RUN_W{1'b1}}};
   localparam logic [SUM_W-1:0]  ERR_MAX    = SUM_W'({ERR_W{1'b1}});

   state_e            state_q, state_d;
   mode_e             mode_q, mode_d;
   logic [ERR_W-1:0]  thr_q, thr_d;
   logic [ERR_W-1:0]  err_q, err_d, err_next;
   logic [RUN_W-1:0]  run_q, run_d, run_next;
   logic [IT_W-1:0]   iter_q, iter_d, iter_next;
   logic              done_q, done_d;
   logic              pass_q, pass_d;

   logic [MISM_W-1:0] mism;
   logic [K-1:0]      seg_match;
   logic [TRL_W-1:0]  trail_run;
   logic [SUM_W-1:0]  err_sum;
   logic [RUN_SW-1:0] run_sum;

   mb_valtrain_seg_cmp #(
      .DATA_W (DATA_W),
      .K      (K),
      .MISM_W (MISM_W),
      .TRL_W  (TRL_W)
   ) u_seg_cmp (
      .i_data      (i_data),
      .o_mism      (mism),
      .o_seg_match (seg_match),
      .o_trail_run (trail_run)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         mode_q  <= MODE_ITER;
         thr_q   <= '0;
         err_q   <= '0;
         run_q   <= '0;
         iter_q  <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         thr_q   <= thr_d;
         err_q   <= err_d;
         run_q   <= run_d;
         iter_q  <= iter_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   // Saturating candidates for the current beat, used only when it is accepted.
   always_comb begin
      err_sum   = SUM_W'(err_q) + SUM_W'(mism);
      err_next  = (err_sum > ERR_MAX) ? '1 : err_sum[ERR_W-1:0];
      run_sum   = {1'b0, run_q} + RUN_STEP;
      if (&seg_match) begin
         run_next = (run_sum > RUN_MAX) ? '1 : run_sum[RUN_W-1:0];
      end else begin
         run_next = RUN_W'(trail_run);
      end
      iter_next = iter_q + ITER_STEP;
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      thr_d   = thr_q;
      err_d   = err_q;
      run_d   = run_q;
      iter_d  = iter_q;
      done_d  = 1'b0;
      pass_d  = pass_q;

      if (i_abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE, DONE: begin
               if (i_start) begin
                  state_d = RUN;
                  mode_d  = mode_e'(i_mode);
                  thr_d   = i_error_threshold;
                  err_d   = '0;
                  run_d   = '0;
                  iter_d  = '0;
                  pass_d  = 1'b0;
               end
            end
            RUN: begin
               if (i_data_valid) begin
                  iter_d = iter_next;
                  if (mode_q == MODE_ITER) begin
                     err_d = err_next;
                     if (iter_next == ITER_LAST) begin
                        pass_d  = (err_next <= thr_q);
                        done_d  = 1'b1;
                        state_d = DONE;
                     end
                  end else begin
                     run_d = run_next;
                     // A streak reaching the target wins even on the budget beat.
                     if (run_next >= RUN_TARGET) begin
                        pass_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                     end else if (iter_next == ITER_LAST) begin
                        pass_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign o_busy         = (state_q == RUN);
   assign o_done         = done_q;
   assign o_pass         = pass_q;
   assign o_error_count  = err_q;
   assign o_consec_count = run_q;

endmodule

// File: tb/tb_mb_valtrain_checker.sv
// Self-checking bench for mb_valtrain_checker: directed vector table, multi-cycle
// corner sequences, and randomized runs against an iteration-history model.
module tb_mb_valtrain_checker;

   logic        clk;
   logic        rst_n;
   logic        start, abort, mode, valid;
   logic [31:0] data;
   logic [11:0] thr;
   logic [8:0]  thr9;

   logic        busy, done, pass;
   logic [11:0] err;
   logic [7:0]  run;
   logic        busy9, done9, pass9;
   logic [8:0]  err9;
   logic [7:0]  run9;

   int total = 0;
   int bad   = 0;

   mb_valtrain_checker #(
      .DATA_W(32), .ITER_COUNT(128), .CONSEC_TARGET(16), .ERR_W(12), .RUN_W(8)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
      .i_data(data), .i_data_valid(valid), .i_error_threshold(thr),
      .o_busy(busy), .o_done(done), .o_pass(pass),
      .o_error_count(err), .o_consec_count(run)
   );

   mb_valtrain_checker #(
      .DATA_W(32), .ITER_COUNT(128), .CONSEC_TARGET(16), .ERR_W(9), .RUN_W(8)
   ) dut9 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_mode(mode),
      .i_data(data), .i_data_valid(valid), .i_error_threshold(thr9),
      .o_busy(busy9), .o_done(done9), .o_pass(pass9),
      .o_error_count(err9), .o_consec_count(run9)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        mode;
      logic [31:0] data;
      logic [11:0] thr;
      logic [8:0]  thr9;
      int          beats;
      int          exp_err;
      int          exp_err9;
      logic        exp_pass;
      logic        exp_pass9;
      int          exp_run;
   } vec_t;

   vec_t vt[7];

   // Model state: every accepted iteration byte of the current run, oldest first.
   logic [7:0] hist[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start cycle also presents a valid beat, which must not be accepted.
   task automatic do_start(input logic m, input logic [11:0] t, input logic [8:0] t9);
      mode  = m;
      thr   = t;
      thr9  = t9;
      start = 1'b1;
      valid = 1'b1;
      data  = 32'h0;
      tick();
      start = 1'b0;
      valid = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      chk("start_err", err, 0);
      chk("start_run", run, 0);
      chk("start_pass", pass, 0);
   endtask

   function automatic int total_err();
      int s = 0;
      foreach (hist[i]) s += $countones(hist[i] ^ 8'h0F);
      return s;
   endfunction

   function automatic int trail_clean();
      int n = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i] != 8'h0F) break;
         n++;
      end
      return n;
   endfunction

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic rand_run(input int idx);
      logic        m;
      logic [11:0] t;
      logic [8:0]  t9;
      logic [31:0] d;
      logic        done_exp, pass_exp, pass9_exp;
      int          cyc, tot, tr;
      m  = 1'($urandom_range(0, 1));
      t  = 12'($urandom_range(0, 300));
      t9 = 9'($urandom_range(0, 300));
      do_start(m, t, t9);
      hist.delete();
      done_exp  = 1'b0;
      pass_exp  = 1'b0;
      pass9_exp = 1'b0;
      cyc = 0;
      while (!done_exp && cyc < 400) begin
         case ($urandom_range(0, 7))
            0, 1, 2, 3, 4: d = 32'h0F0F0F0F;
            5:             d = 32'h0F0F0F0F ^ (32'h1 << $urandom_range(0, 31));
            default:       d = (m == 1'b0) ? $urandom : (32'h0F0F0F0F ^ (32'h1 << $urandom_range(0, 31)));
         endcase
         data  = d;
         valid = ($urandom_range(0, 3) != 0);
         // Mid-run start/mode/threshold changes must all be ignored.
         start = ($urandom_range(0, 15) == 0);
         mode  = 1'($urandom_range(0, 1));
         thr   = 12'($urandom);
         thr9  = 9'($urandom);
         tick();
         cyc++;
         if (valid) begin
            for (int j = 0; j < 4; j++) hist.push_back(d[8*j +: 8]);
            tot = total_err();
            tr  = trail_clean();
            if (m == 1'b0) begin
               if (hist.size() == 128) begin
                  done_exp  = 1'b1;
                  pass_exp  = (min_i(tot, 4095) <= int'(t));
                  pass9_exp = (min_i(tot, 511) <= int'(t9));
               end
            end else if (tr >= 16) begin
               done_exp = 1'b1; pass_exp = 1'b1; pass9_exp = 1'b1;
            end else if (hist.size() == 128) begin
               done_exp = 1'b1; pass_exp = 1'b0; pass9_exp = 1'b0;
            end
         end
         chk("rnd_done", done, done_exp);
         chk("rnd_busy", busy, !done_exp);
         if (m == 1'b0) begin
            chk("rnd_err", err, min_i(total_err(), 4095));
            chk("rnd_err9", err9, min_i(total_err(), 511));
         end else begin
            chk("rnd_run", run, min_i(trail_clean(), 255));
            chk("rnd_run9", run9, min_i(trail_clean(), 255));
         end
      end
      start = 1'b0;
      valid = 1'b0;
      chk("rnd_finished", done_exp, 1);
      if (done_exp) begin
         chk("rnd_pass", pass, pass_exp);
         chk("rnd_pass9", pass9, pass9_exp);
         tick();
         chk("rnd_done_1cyc", done, 0);
         chk("rnd_pass_held", pass, pass_exp);
      end
   endtask

   initial begin
      logic [31:0] cdata[5];
      int          cruns[5];
      int          seen;
      int          done_at;

      start = 1'b0; abort = 1'b0; mode = 1'b0; valid = 1'b0;
      data = '0; thr = '0; thr9 = '0;
      rst_n = 1'b0;

      vt[0] = '{1'b0, 32'h0F0F0F0F, 12'd0,    9'd0,   32, 0,   0,   1'b1, 1'b1, 0};
      vt[1] = '{1'b0, 32'h0F0F0F0E, 12'd31,   9'd31,  32, 32,  32,  1'b0, 1'b0, 0};
      vt[2] = '{1'b0, 32'h0F0F0F0E, 12'd32,   9'd32,  32, 32,  32,  1'b1, 1'b1, 0};
      vt[3] = '{1'b0, 32'h00000000, 12'd4095, 9'd500, 32, 512, 511, 1'b1, 1'b0, 0};
      vt[4] = '{1'b1, 32'h0F000F0F, 12'd0,    9'd0,   32, 0,   0,   1'b0, 1'b0, 1};
      vt[5] = '{1'b1, 32'h0F0F0F0F, 12'd0,    9'd0,   4,  0,   0,   1'b1, 1'b1, 16};
      vt[6] = '{1'b0, 32'hFFFFFFFF, 12'd511,  9'd511, 32, 512, 511, 1'b0, 1'b1, 0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err, 0);
      chk("rst_run", run, 0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      foreach (vt[v]) begin
         do_start(vt[v].mode, vt[v].thr, vt[v].thr9);
         for (int b = 0; b < vt[v].beats; b++) begin
            data  = vt[v].data;
            valid = 1'b1;
            tick();
            chk("vec_done_timing", done, (b == vt[v].beats - 1));
         end
         valid = 1'b0;
         chk("vec_pass", pass, vt[v].exp_pass);
         chk("vec_pass9", pass9, vt[v].exp_pass9);
         chk("vec_busy", busy, 0);
         if (vt[v].mode == 1'b0) begin
            chk("vec_err", err, vt[v].exp_err);
            chk("vec_err9", err9, vt[v].exp_err9);
         end else begin
            chk("vec_run", run, vt[v].exp_run);
            chk("vec_run9", run9, vt[v].exp_run);
         end
         tick();
         chk("vec_done_low", done, 0);
         chk("vec_pass_held", pass, vt[v].exp_pass);
      end

      // CONSEC streak built from a partial beat followed by clean beats.
      cdata = '{32'h0F0F000F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F, 32'h0F0F0F0F};
      cruns = '{2, 6, 10, 14, 18};
      do_start(1'b1, 12'd0, 9'd0);
      for (int b = 0; b < 5; b++) begin
         data  = cdata[b];
         valid = 1'b1;
         tick();
         chk("consec_run", run, cruns[b]);
         chk("consec_done", done, (b == 4));
      end
      valid = 1'b0;
      chk("consec_pass", pass, 1);

      // ITER with a 5-cycle valid gap after beat 10.
      do_start(1'b0, 12'd32, 9'd32);
      seen = 0;
      done_at = -1;
      for (int c = 1; c <= 60 && done_at < 0; c++) begin
         valid = !(seen >= 10 && seen < 15 && c > 10 && c <= 15);
         data  = valid ? 32'h0F0F0F0E : 32'h00000000;
         tick();
         if (valid) seen++;
         if (c > 10 && c <= 15) begin
            chk("gap_err_frozen", err, 10);
            chk("gap_busy", busy, 1);
         end
         if (done) done_at = c;
      end
      valid = 1'b0;
      chk("gap_done_cycle", done_at, 37);
      chk("gap_err", err, 32);
      chk("gap_pass", pass, 1);

      // Abort at beat 10: back to IDLE with no done pulse.
      do_start(1'b0, 12'd0, 9'd0);
      for (int b = 0; b < 10; b++) begin
         data = 32'h0F0F0F0F; valid = 1'b1; tick();
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done) seen++;
      end
      valid = 1'b0;
      chk("abort_no_done", seen, 0);
      chk("abort_idle", busy, 0);

      // Abort and start together: abort wins.
      start = 1'b1; abort = 1'b1; mode = 1'b0;
      tick();
      start = 1'b0; abort = 1'b0;
      chk("abort_start_busy", busy, 0);

      for (int r = 0; r < 30; r++) rand_run(r);

      // Asynchronous reset mid-run.
      do_start(1'b0, 12'd0, 9'd0);
      for (int b = 0; b < 10; b++) begin
         data = 32'h0F0F0F0E; valid = 1'b1; tick();
      end
      chk("arst_pre_err", err, 10);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_pass", pass, 0);
      chk("arst_err", err, 0);
      chk("arst_err9", err9, 0);
      chk("arst_run", run, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();
      valid = 1'b0;
      chk("arst_stay_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

endmodule
